// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : instruction fetch engine feeding a circular instruction queue
// Rev 1.0
// ============================================================================

package fetch_queue_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH  = 4,
  parameter logic [63:0] PCINIT = 64'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  output ibus_req_t              ireq,
  input  ibus_resp_t             iresp,
  input  logic                   redirect_valid,
  input  logic [63:0]            redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_ins,
  output logic [63:0]            out_pc,
  output logic                   out_misalign,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    HALT = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [63:0] pc;
    logic        misalign;
  } entry_t;

  state_t             state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic [63:0]        req_addr_q, req_addr_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  entry_t             mem_q [DEPTH];

  logic               push;
  logic               pop;
  logic               flush;
  entry_t             push_entry;
  logic               full;
  logic [63:0]        seq_pc;
  logic [CNT_W-1:0]   count_pp;
  logic               unused_addr_ok;

  assign unused_addr_ok = iresp.addr_ok;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign out_valid = (count_q != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign seq_pc    = req_addr_q + 64'd4;
  // occupancy once the word returned this cycle lands and any pop retires
  assign count_pp  = count_q + CNT_W'(1) - CNT_W'(pop);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    flush      = 1'b0;
    push_entry = '0;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = redirect_pc;
        end else if (!full) begin
          if (pc_q[1:0] == 2'b00) begin
            req_addr_d = pc_q;
            state_d    = WAIT;
          end else begin
            push                = 1'b1;
            push_entry.pc       = pc_q;
            push_entry.misalign = 1'b1;
            state_d             = HALT;
          end
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = redirect_pc;
          state_d = iresp.data_ok ? IDLE : DROP;
        end else if (iresp.data_ok) begin
          push           = 1'b1;
          push_entry.ins = iresp.data;
          push_entry.pc  = req_addr_q;
          pc_d           = seq_pc;
          if ((count_pp < CNT_W'(DEPTH)) && (seq_pc[1:0] == 2'b00)) begin
            req_addr_d = seq_pc;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        // the queue was already flushed on entry, so a redirect only moves the pc
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        if (iresp.data_ok) begin
          state_d = IDLE;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = redirect_pc;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= PCINIT;
      req_addr_q <= PCINIT;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // payload storage needs no reset: contents are only visible behind count
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem_q[tail_q] <= push_entry;
    end
  end

  assign ireq.valid   = (state_q == WAIT) || (state_q == DROP);
  assign ireq.addr    = req_addr_q;
  assign out_ins      = mem_q[head_q].ins;
  assign out_pc       = mem_q[head_q].pc;
  assign out_misalign = mem_q[head_q].misalign;
  assign count        = count_q;

endmodule

`default_nettype wire
